// File: rtl/matrix_pkg.sv
// Shared definitions for the packed-matrix datapath: default geometry, element
// type, serializer state encoding and the element bit-offset helper.
package matrix_pkg;

    localparam int MATRIX_SIZE_DEF = 8;
    localparam int ELEM_WIDTH_DEF  = 16;

    typedef logic [ELEM_WIDTH_DEF-1:0] elem_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } ser_state_t;

    // Element (0,0) sits in the MSBs, so offsets count down from the top of the bus.
    function automatic int elem_lsb(input int r, input int c,
                                    input int n  = MATRIX_SIZE_DEF,
                                    input int ew = ELEM_WIDTH_DEF);
        return (n * n - 1 - (r * n + c)) * ew;
    endfunction

endpackage

// File: rtl/matrix_index_counter.sv
// Row/column walker for the serializer: row- or column-major order,
// wrap at MATRIX_SIZE-1 and last-element detection.
module matrix_index_counter #(
    parameter int MATRIX_SIZE = 8,
    parameter int IDX_W       = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             advance_i,
    input  logic             col_major_i,
    output logic [IDX_W-1:0] row_o,
    output logic [IDX_W-1:0] col_o,
    output logic             last_o
);

    localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(MATRIX_SIZE - 1);

    logic [IDX_W-1:0] row_q, row_d;
    logic [IDX_W-1:0] col_q, col_d;

    // Clear wins over advance so a back-to-back capture restarts at (0,0).
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clear_i) begin
            row_d = '0;
            col_d = '0;
        end else if (advance_i) begin
            if (!col_major_i) begin
                if (col_q == MAX_IDX) begin
                    col_d = '0;
                    row_d = (row_q == MAX_IDX) ? '0 : row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end else begin
                if (row_q == MAX_IDX) begin
                    row_d = '0;
                    col_d = (col_q == MAX_IDX) ? '0 : col_q + 1'b1;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o  = row_q;
    assign col_o  = col_q;
    assign last_o = (row_q == MAX_IDX) && (col_q == MAX_IDX);

endmodule

// File: rtl/matrix_result_serializer.sv
// Captures one packed MATRIX_SIZE x MATRIX_SIZE word and streams it out one
// element per accepted beat, tagged with row/column and a last flag.
module matrix_result_serializer
    import matrix_pkg::*;
#(
    parameter  int DATA_WIDTH  = 1024,
    parameter  int MATRIX_SIZE = MATRIX_SIZE_DEF,
    parameter  int ELEM_WIDTH  = ELEM_WIDTH_DEF,
    localparam int IDX_W       = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_col_major,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ELEM_WIDTH-1:0] out_data,
    output logic [IDX_W-1:0]      out_row,
    output logic [IDX_W-1:0]      out_col,
    output logic                  out_last,
    output logic                  busy
);

    localparam int LSB_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    if (DATA_WIDTH != ELEM_WIDTH * MATRIX_SIZE * MATRIX_SIZE) begin : g_bad_width
        $error("DATA_WIDTH must equal ELEM_WIDTH*MATRIX_SIZE*MATRIX_SIZE");
    end

    ser_state_t            state_q;
    logic [DATA_WIDTH-1:0] hold_q;
    logic                  col_major_q;
    logic                  capture;
    logic                  beat;
    logic [LSB_W-1:0]      lsb;

    assign out_valid = (state_q == ST_STREAM);
    assign busy      = (state_q == ST_STREAM);
    assign beat      = out_valid && out_ready;
    // Accepting the last beat frees the holding register in the same cycle.
    assign in_ready  = (state_q == ST_IDLE) || (beat && out_last);
    assign capture   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            col_major_q <= 1'b0;
        end else if (capture) begin
            state_q     <= ST_STREAM;
            hold_q      <= in_data;
            col_major_q <= in_col_major;
        end else if (beat && out_last) begin
            state_q     <= ST_IDLE;
        end
    end

    matrix_index_counter #(
        .MATRIX_SIZE (MATRIX_SIZE),
        .IDX_W       (IDX_W)
    ) u_idx (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (capture),
        .advance_i   (beat),
        .col_major_i (col_major_q),
        .row_o       (out_row),
        .col_o       (out_col),
        .last_o      (out_last)
    );

    assign lsb      = LSB_W'(elem_lsb(int'(out_row), int'(out_col), MATRIX_SIZE, ELEM_WIDTH));
    assign out_data = hold_q[lsb +: ELEM_WIDTH];

endmodule

// File: tb/tb_matrix_result_serializer.sv
// Directed/randomized bench for matrix_result_serializer against a queue-based
// model of the expected element order.
module tb_matrix_result_serializer;

    localparam int N  = 8;
    localparam int EW = 16;
    localparam int DW = N * N * EW;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          in_col_major = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [EW-1:0] out_data;
    logic [IW-1:0] out_row;
    logic [IW-1:0] out_col;
    logic          out_last;
    logic          busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    matrix_result_serializer #(
        .DATA_WIDTH  (DW),
        .MATRIX_SIZE (N),
        .ELEM_WIDTH  (EW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_col_major (in_col_major),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_row      (out_row),
        .out_col      (out_col),
        .out_last     (out_last),
        .busy         (busy)
    );

    typedef struct {
        logic [EW-1:0] d;
        int            r;
        int            c;
        bit            last;
    } beat_t;

    beat_t         exp_q[$];
    logic [EW-1:0] mat[N][N];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected beat order straight from the ordering rule: beat k walks columns
    // fastest in row-major mode and rows fastest in column-major mode.
    task automatic push_model(input bit cm);
        for (int k = 0; k < N * N; k++) begin
            int r;
            int c;
            r = cm ? (k % N) : (k / N);
            c = cm ? (k / N) : (k % N);
            exp_q.push_back('{mat[r][c], r, c, (k == N * N - 1)});
        end
    endtask

    function automatic logic [DW-1:0] pack_mat();
        logic [DW-1:0] w;
        w = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                w[DW-1-EW*(r*N+c) -: EW] = mat[r][c];
        return w;
    endfunction

    task automatic fill_mat(input int mode, input logic [EW-1:0] base);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                mat[r][c] = (mode == 0) ? EW'(base + EW'(r * N + c)) : EW'($urandom);
    endtask

    // Present the word until captured, then scramble the inputs so any
    // re-sampling of in_data / in_col_major would show up in the stream.
    task automatic load(input bit cm);
        int t;
        t = 0;
        @(negedge clk);
        in_data = pack_mat();
        in_col_major = cm;
        in_valid = 1'b1;
        #1;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("load_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_col_major = ~cm;
        in_data = ~in_data;
        push_model(cm);
    endtask

    // Consume nb beats with out_ready high pct% of cycles; inj>=0 pulses a stray
    // in_valid at that beat. Checks every valid cycle against the model.
    task automatic drain(input int nb, input int pct, input int inj, output int cyc);
        int            got;
        bit            stalled;
        bit            clr_v;
        bit            injected;
        logic [EW-1:0] pd;
        logic [IW-1:0] pr;
        logic [IW-1:0] pc;
        logic          pl;
        beat_t         e;
        got = 0;
        cyc = 0;
        stalled = 0;
        clr_v = 0;
        injected = 0;
        while (got < nb && cyc < 2000) begin
            @(negedge clk);
            if (clr_v) begin
                in_valid = 1'b0;
                clr_v = 0;
            end
            if (got == inj && !injected) begin
                in_valid = 1'b1;
                in_data = {DW/32{$urandom}};
                in_col_major = ~in_col_major;
                injected = 1;
                clr_v = 1;
            end
            out_ready = ($urandom_range(99) < pct);
            #1;
            cyc++;
            chk("valid", out_valid, 1);
            chk("busy", busy, 1);
            if (stalled) begin
                chk("stall_data", out_data, pd);
                chk("stall_row", out_row, pr);
                chk("stall_col", out_col, pc);
                chk("stall_last", out_last, pl);
            end
            if (exp_q.size() == 0) begin
                chk("extra_beat", out_valid, 0);
            end else if (out_valid) begin
                e = exp_q[0];
                chk("data", out_data, e.d);
                chk("row", out_row, e.r);
                chk("col", out_col, e.c);
                chk("last", out_last, e.last);
                chk("in_ready", in_ready, e.last && out_ready);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    got++;
                    stalled = 0;
                    if (e.last && in_valid) clr_v = 1;
                end else begin
                    stalled = 1;
                    pd = out_data;
                    pr = out_row;
                    pc = out_col;
                    pl = out_last;
                end
            end
        end
        chk("drain_beats", got, nb);
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
    endtask

    initial begin
        int cyc;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data", out_data, 0);
        chk("rst_row", out_row, 0);
        chk("rst_col", out_col, 0);
        chk("rst_last", out_last, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);

        // Row-major, value r*8+c
        fill_mat(0, 16'h0000);
        load(1'b0);
        drain(64, 100, -1, cyc);
        chk("rm_cycles", cyc, 64);
        check_idle("rm_end");

        // Same word, column-major
        load(1'b1);
        drain(64, 100, -1, cyc);
        check_idle("cm_end");

        // Random word, random order, 50% backpressure
        fill_mat(1, 16'h0000);
        load(1'($urandom));
        drain(64, 50, -1, cyc);
        check_idle("bp_end");

        // Back-to-back words, in_valid held through the first matrix
        fill_mat(0, 16'hA000);
        @(negedge clk);
        in_data = pack_mat();
        in_col_major = 1'b0;
        in_valid = 1'b1;
        #1;
        chk("b2b_ready", in_ready, 1);
        @(posedge clk);
        #1;
        push_model(1'b0);
        fill_mat(0, 16'hB000);
        in_data = pack_mat();
        push_model(1'b0);
        drain(128, 100, -1, cyc);
        chk("b2b_cycles", cyc, 128);
        chk("b2b_valid_dropped", in_valid, 0);
        check_idle("b2b_end");

        // Async reset mid-stream
        fill_mat(1, 16'h0000);
        load(1'b0);
        drain(20, 100, -1, cyc);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_data", out_data, 0);
        chk("arst_row", out_row, 0);
        chk("arst_col", out_col, 0);
        chk("arst_last", out_last, 0);
        exp_q.delete();
        @(negedge clk);
        out_ready = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("arst_in_ready", in_ready, 1);
        fill_mat(1, 16'h0000);
        load(1'b1);
        drain(64, 100, -1, cyc);
        check_idle("arst_end");

        // Stray in_valid at beat 10 must be ignored
        fill_mat(1, 16'h0000);
        load(1'b0);
        drain(64, 100, 10, cyc);
        check_idle("stray_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/matrix_result_serializer.md
Name: matrix_result_serializer

Overview:
- Reader side of the flat packed-matrix bus produced by the matrix add/subtract unit.
- Captures one packed MATRIX_SIZE x MATRIX_SIZE result word through a valid/ready handshake.
- Streams the result out as ELEM_WIDTH-bit elements, one per accepted beat, with row/column tags and a last flag.
- Feeds narrow consumers (UART/memory writer, checker) from the wide combinational datapath.

Parameters:
- DATA_WIDTH, 1024, width of the packed matrix bus; must equal ELEM_WIDTH*MATRIX_SIZE*MATRIX_SIZE (elaboration error otherwise).
- MATRIX_SIZE, 8, rows = columns.
- ELEM_WIDTH, 16, bits per element.
- IDX_W, $clog2(MATRIX_SIZE) (min 1), width of the row/column index ports; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  packed word on in_data is valid.
- in_ready  out  1  block can capture a word this cycle.
- in_data  in  DATA_WIDTH  packed matrix; element (r,c) occupies bits [DATA_WIDTH-1-ELEM_WIDTH*(r*MATRIX_SIZE+c) -: ELEM_WIDTH], so (0,0) is in the MSBs.
- in_col_major  in  1  sampled with the word: 0 = emit row-major, 1 = emit column-major (transposed order).
- out_valid  out  1  out_data/out_row/out_col/out_last are valid.
- out_ready  in  1  consumer accepts the current beat.
- out_data  out  ELEM_WIDTH  current element.
- out_row  out  IDX_W  row index of out_data.
- out_col  out  IDX_W  column index of out_data.
- out_last  out  1  high on the final (MATRIX_SIZE^2-th) beat.
- busy  out  1  high while a word is held (STREAM state).

Behaviour:
- Reset (rst_n low, async): state=IDLE; out_valid=0, out_last=0, out_data=0, out_row=0, out_col=0, busy=0; holding register cleared; in_ready=1 once reset releases.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready: latch in_data and in_col_major, zero both indices, go to STREAM.
  - STREAM: out_valid=1. On a beat (out_valid&&out_ready), advance the indices.
    - Row-major: col increments, wraps to 0 with row+1.
    - Col-major: row increments, wraps to 0 with col+1.
- Latency: first element valid the cycle after capture. No bubbles between beats under continuous out_ready. A full matrix takes MATRIX_SIZE^2 beats.
- out_data is always the element of the held word at the current (out_row,out_col), muxed from the register and not re-sampled from in_data.
- Backpressure: while out_valid && !out_ready, out_data, out_row, out_col and out_last hold stable. out_valid never drops mid-matrix.
- out_last = 1 exactly when both indices equal MATRIX_SIZE-1.
- End of matrix: when a beat is accepted with out_last=1:
  - Back-to-back: in_ready is also 1 in that cycle, combinationally (in_ready = IDLE || (out_valid && out_ready && out_last)). If in_valid is also 1, capture the new word, reset the indices and stay in STREAM. The next element is (0,0) of the new matrix on the following cycle.
  - Otherwise return to IDLE.
- in_valid during STREAM before the last beat: ignored (in_ready=0). The upstream holds in_data per the handshake.
- in_col_major changes outside a capture cycle have no effect.
- busy = (state==STREAM).
- Arithmetic: elements pass through untouched; no sign interpretation. Index counters are IDX_W bits and compare against MATRIX_SIZE-1, so non-power-of-2 MATRIX_SIZE works.
- Reset asserted mid-stream aborts the matrix immediately; no partial flush. After release the block is in IDLE.

Decomposition:
- Shared package matrix_pkg holds:
  - constants MATRIX_SIZE_DEF=8, ELEM_WIDTH_DEF=16
  - function elem_lsb(r,c) returning the bit offset of element (r,c), used by this block and by the packing/loader side
  - typedef elem_t (logic [ELEM_WIDTH_DEF-1:0]).
- One sub-module is natural: matrix_index_counter (row/col counters with order select, wrap and last detection). Everything else stays in the top.

Test Plan:
- Reset then load with element value = r*8+c (row-major) -> beats 0..63 carry out_data 0x0000..0x003F; (row,col) (0,0)..(7,7); out_last only on beat 64; then in_ready=1, busy=0.
- Same word with in_col_major=1 -> beat 1 (0,0)=0x0000, beat 2 (1,0)=0x0008, beat 9 (0,1)=0x0001; last beat (7,7)=0x003F.
- out_ready toggling pseudo-randomly 50% -> 64 beats in order, outputs stable across every stalled cycle, no duplicates or drops.
- Two words (values 0xA000+k, then 0xB000+k) with in_valid held continuously and out_ready=1 -> 128 consecutive out_valid cycles, no bubble; 0xB000 at (0,0) follows 0xA03F immediately.
- rst_n pulsed low at beat 20 (async, between edges) -> outputs zero within the same cycle; after release in_ready=1 and a new load starts cleanly from (0,0).
- in_valid pulsed with a different word at beat 10 -> ignored; stream continues with original data through beat 64.
